// File: rtl/sp_access_pkg.sv
// ---------------------------------------------------------------------------
// sp_access_pkg
//   Shared types and sizing helpers for the scratchpad access controller.
//   - state_t : controller FSM states
//   - grant_t : which request type was granted most recently
//   - calc_* : derive matrix dimension, in-matrix address width and target
//              select width from the top-level parameters
// ---------------------------------------------------------------------------
package sp_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

    // One bus word carries one full matrix row.
    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    // Row and column indices are packed side by side.
    function automatic int calc_addr_w(input int max_dim);
        return 2 * $clog2(max_dim);
    endfunction

    // A single target still needs a 1-bit select.
    function automatic int calc_tgt_w(input int ntargets);
        return (ntargets > 1) ? $clog2(ntargets) : 1;
    endfunction

endpackage

// File: rtl/sp_access_ctrl.sv
// ---------------------------------------------------------------------------
// sp_access_ctrl
//   Sequences every access to the result-matrix scratchpad. Burst write-backs
//   of a full MAX_DIM x MAX_DIM matrix from the matmul engine and single-row
//   host reads are arbitrated in IDLE, alternating priority when both are
//   pending.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_start_i/_target_i  write-back request (level) and destination target
//   wb_ack_o              one-cycle write grant
//   wb_valid_i/_data_i    write beats; wb_ready_o while accepting beats
//   wb_done_o             one-cycle pulse after the last beat
//   rd_req_i/_target_i/_addr_i  host read request (level), target, address
//   rd_ack_o              one-cycle read grant
//   rd_valid_o/rd_data_o  read data strobe and registered (held) read data
//   busy_o                controller not idle
//   sp_*_o / sp_data_i    scratchpad control, address, data in/out
// ---------------------------------------------------------------------------
module sp_access_ctrl
    import sp_access_pkg::*;
#(
    parameter  int SP_NTARGETS = 4,
    parameter  int DATA_WIDTH  = 32,
    parameter  int BUS_WIDTH   = 64,
    localparam int MAX_DIM     = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int ADDR_W      = calc_addr_w(MAX_DIM),
    localparam int TGT_W       = calc_tgt_w(SP_NTARGETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 wb_start_i,
    input  logic [TGT_W-1:0]     wb_target_i,
    output logic                 wb_ack_o,
    input  logic                 wb_valid_i,
    input  logic [BUS_WIDTH-1:0] wb_data_i,
    output logic                 wb_ready_o,
    output logic                 wb_done_o,

    input  logic                 rd_req_i,
    input  logic [TGT_W-1:0]     rd_target_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic                 rd_ack_o,
    output logic                 rd_valid_o,
    output logic [BUS_WIDTH-1:0] rd_data_o,

    output logic                 busy_o,

    output logic                 sp_write_enable_o,
    output logic [ADDR_W-1:0]    sp_address_o,
    output logic [TGT_W-1:0]     sp_write_target_o,
    output logic [TGT_W-1:0]     sp_read_target_o,
    output logic                 sp_mode_o,
    output logic [BUS_WIDTH-1:0] sp_data_o,
    input  logic [BUS_WIDTH-1:0] sp_data_i
);

    // Address of the final beat of a burst.
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(MAX_DIM * MAX_DIM - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                 r_state;
    grant_t                 r_last_grant;
    logic [ADDR_W-1:0]      r_cnt;
    logic [TGT_W-1:0]       r_wr_tgt;
    logic [TGT_W-1:0]       r_rd_tgt;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [BUS_WIDTH-1:0]   r_rd_data;
    logic                   r_rd_valid;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    state_t                 w_next_state;
    logic                   w_gnt_wr;
    logic                   w_gnt_rd;
    logic                   w_beat;
    logic                   w_last_beat;
    logic                   w_wr_tgt_ok;
    logic                   w_rd_tgt_ok;

    assign w_beat      = (r_state == ST_WRITE) && wb_valid_i;
    assign w_last_beat = w_beat && (r_cnt == LAST_BEAT);

    // Targets beyond SP_NTARGETS only exist when the count is not a power of
    // two; such accesses are still handshaken but never touch the scratchpad.
    assign w_wr_tgt_ok = (int'(r_wr_tgt) < SP_NTARGETS);
    assign w_rd_tgt_ok = (int'(r_rd_tgt) < SP_NTARGETS);

    // -----------------------------------------------------------------------
    // Arbitration: only in IDLE. Grants are suppressed while rst_i is high so
    // a requester never sees an ack for an operation the reset discards.
    // -----------------------------------------------------------------------
    always_comb begin
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        if (r_state == ST_IDLE && !rst_i) begin
            if (wb_start_i && rd_req_i) begin
                // Conflict: whoever did not win last time goes now.
                if (r_last_grant == GNT_READ) w_gnt_wr = 1'b1;
                else                          w_gnt_rd = 1'b1;
            end else begin
                w_gnt_wr = wb_start_i;
                w_gnt_rd = rd_req_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_wr)      w_next_state = ST_WRITE;
                else if (w_gnt_rd) w_next_state = ST_READ;
            end
            ST_WRITE: begin
                // Stalls indefinitely while wb_valid_i is low.
                if (w_last_beat) w_next_state = ST_DONE;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_READ:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        wb_ack_o          = w_gnt_wr;
        rd_ack_o          = w_gnt_rd;
        wb_ready_o        = 1'b0;
        wb_done_o         = 1'b0;
        sp_write_enable_o = 1'b0;
        sp_address_o      = '0;
        sp_write_target_o = '0;
        sp_read_target_o  = '0;
        sp_mode_o         = 1'b0;
        sp_data_o         = '0;
        case (r_state)
            ST_WRITE: begin
                wb_ready_o        = 1'b1;
                sp_write_enable_o = wb_valid_i && w_wr_tgt_ok;
                sp_address_o      = r_cnt;
                sp_write_target_o = r_wr_tgt;
                sp_data_o         = wb_data_i;
            end
            ST_DONE: begin
                wb_done_o = 1'b1;
            end
            ST_READ: begin
                // Scratchpad outputs are only driven while mode is high.
                sp_mode_o        = 1'b1;
                sp_address_o     = r_rd_addr;
                sp_read_target_o = r_rd_tgt;
            end
            default: ;
        endcase
    end

    assign busy_o     = (r_state != ST_IDLE);
    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_rd_data;

    // -----------------------------------------------------------------------
    // Datapath: request latches, beat counter, read capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= GNT_READ;
            r_cnt        <= '0;
            r_wr_tgt     <= '0;
            r_rd_tgt     <= '0;
            r_rd_addr    <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            // The READ cycle's data becomes visible one cycle later, in IDLE.
            r_rd_valid <= (r_state == ST_READ);

            if (w_gnt_wr) begin
                r_wr_tgt     <= wb_target_i;
                r_cnt        <= '0;
                r_last_grant <= GNT_WRITE;
            end

            if (w_gnt_rd) begin
                r_rd_tgt     <= rd_target_i;
                r_rd_addr    <= rd_addr_i;
                r_last_grant <= GNT_READ;
            end

            if (w_beat) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + ADDR_W'(1);
            end

            // rd_data_o holds its value until the next read completes.
            if (r_state == ST_READ) begin
                r_rd_data <= w_rd_tgt_ok ? sp_data_i : '0;
            end
        end
    end

endmodule

// File: tb/tb_sp_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_access_ctrl
//   Two controllers share one stimulus stream: one with 4 targets, one with 3
//   (so target 3 is out of range). Each has a behavioural scratchpad behind
//   it. Expected data comes from ref_mem, filled from the beats the bench
//   sends; grant order comes from a "last granted type" model.
// ---------------------------------------------------------------------------
module tb_sp_access_ctrl;

    localparam int BW = 64;
    localparam int AW = 2;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wb_start;
    logic [TW-1:0] wb_target;
    logic          wb_valid;
    logic [BW-1:0] wb_data;
    logic          rd_req;
    logic [TW-1:0] rd_target;
    logic [AW-1:0] rd_addr;

    logic          wb_ack   [2];
    logic          wb_ready [2];
    logic          wb_done  [2];
    logic          rd_ack   [2];
    logic          rd_valid [2];
    logic [BW-1:0] rd_data  [2];
    logic          busy     [2];
    logic          sp_we    [2];
    logic [AW-1:0] sp_addr  [2];
    logic [TW-1:0] sp_wt    [2];
    logic [TW-1:0] sp_rt    [2];
    logic          sp_mode  [2];
    logic [BW-1:0] sp_do    [2];
    logic [BW-1:0] sp_di    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NT = (g == 0) ? 4 : 3;
        logic [BW-1:0] spm [4][4];

        sp_access_ctrl #(.SP_NTARGETS(NT)) u_dut (
            .clk_i             (clk),
            .rst_i             (rst),
            .wb_start_i        (wb_start),
            .wb_target_i       (wb_target),
            .wb_ack_o          (wb_ack[g]),
            .wb_valid_i        (wb_valid),
            .wb_data_i         (wb_data),
            .wb_ready_o        (wb_ready[g]),
            .wb_done_o         (wb_done[g]),
            .rd_req_i          (rd_req),
            .rd_target_i       (rd_target),
            .rd_addr_i         (rd_addr),
            .rd_ack_o          (rd_ack[g]),
            .rd_valid_o        (rd_valid[g]),
            .rd_data_o         (rd_data[g]),
            .busy_o            (busy[g]),
            .sp_write_enable_o (sp_we[g]),
            .sp_address_o      (sp_addr[g]),
            .sp_write_target_o (sp_wt[g]),
            .sp_read_target_o  (sp_rt[g]),
            .sp_mode_o         (sp_mode[g]),
            .sp_data_o         (sp_do[g]),
            .sp_data_i         (sp_di[g])
        );

        // Behavioural scratchpad; junk outside read mode or for a missing
        // target so that any unmasked sampling shows up in rd_data_o.
        always @(posedge clk) if (sp_we[g]) spm[sp_wt[g]][sp_addr[g]] <= sp_do[g];
        assign sp_di[g] = !sp_mode[g]               ? 64'hBAD0_BAD0_BAD0_BAD0 :
                          (int'(sp_rt[g]) >= NT)     ? 64'hDEAD_BEEF_DEAD_BEEF :
                                                       spm[sp_rt[g]][sp_addr[g]];
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    int            sel     = 0;     // which controller is being observed
    bit            m_last_wr = 1'b0; // model: most recent grant was a write
    logic [BW-1:0] ref_mem [2][4][4];

    function automatic int nt_of(int s);
        return (s == 0) ? 4 : 3;
    endfunction

    function automatic logic [BW-1:0] exp_rd(int s, int t, int a);
        return (t < nt_of(s)) ? ref_mem[s][t][a] : '0;
    endfunction

    function automatic int exp_we(int s, int t);
        return (t < nt_of(s)) ? 4 : 0;
    endfunction

    task automatic ref_wr(int t, int a, logic [BW-1:0] d);
        ref_mem[0][t][a] = d;
        if (t < nt_of(1)) ref_mem[1][t][a] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; wb_start = 1'b0; wb_target = '0; wb_valid = 1'b0;
        wb_data = '0; rd_req = 1'b0; rd_target = '0; rd_addr = '0;
        nxt();
        nxt();
        rst = 1'b0;
        m_last_wr = 1'b0;
    endtask

    // Drives beats from the first WRITE cycle until wb_done_o, collecting what
    // the scratchpad port did. Returns at the start of the following cycle.
    task automatic drive_burst(input int tgt, input bit seq_data, input logic [15:0] pat,
                               input int plen, output int n_we, output int bad, output int gap);
        int k;
        int c;
        bit v;
        k = 0; c = 0; n_we = 0; bad = 0; gap = 0;
        while (k < 4 && c < 64) begin
            v        = (c < plen) ? pat[c] : 1'b1;
            wb_valid = v;
            wb_data  = seq_data ? 64'(k + 1) * 64'h11 : {$urandom, $urandom};
            smp();
            if (sp_we[sel]) begin
                if (sp_addr[sel] !== AW'(n_we) || sp_wt[sel] !== TW'(tgt) || sp_do[sel] !== wb_data) bad++;
                n_we++;
            end
            if (wb_done[sel] || !wb_ready[sel] || rd_ack[sel] || wb_ack[sel] || sp_mode[sel]) bad++;
            if (v) begin
                ref_wr(tgt, k, wb_data);
                k++;
            end
            c++;
            nxt();
        end
        wb_valid = 1'b0;
        gap = 1;
        smp();
        while (!wb_done[sel] && gap < 8) begin
            gap++;
            nxt();
            smp();
        end
        nxt();
    endtask

    task automatic write_txn(input int tgt, input bit seq_data, input logic [15:0] pat, input int plen,
                             output bit ack, output int n_we, output int bad, output int gap);
        wb_start  = 1'b1;
        wb_target = TW'(tgt);
        smp();
        ack = wb_ack[sel] && !rd_ack[sel] && !busy[sel];
        nxt();
        wb_start  = 1'b0;
        m_last_wr = 1'b1;
        drive_burst(tgt, seq_data, pat, plen, n_we, bad, gap);
    endtask

    task automatic read_txn(input int tgt, input int addr, output bit ack, output bit phase_ok,
                            output bit vld, output logic [BW-1:0] data);
        rd_req    = 1'b1;
        rd_target = TW'(tgt);
        rd_addr   = AW'(addr);
        smp();
        ack = rd_ack[sel] && !wb_ack[sel];
        nxt();
        rd_req    = 1'b0;
        m_last_wr = 1'b0;
        smp();
        phase_ok = sp_mode[sel] && sp_addr[sel] === AW'(addr) && sp_rt[sel] === TW'(tgt)
                   && !sp_we[sel] && !rd_valid[sel] && busy[sel];
        nxt();
        smp();
        vld  = rd_valid[sel];
        data = rd_data[sel];
        nxt();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [141:0] obs;
        apply_reset();
        smp();
        for (int s = 0; s < 2; s++) begin
            obs = {wb_ack[s], wb_ready[s], wb_done[s], rd_ack[s], rd_valid[s], busy[s], sp_we[s],
                   sp_mode[s], sp_addr[s], sp_wt[s], sp_rt[s], rd_data[s], sp_do[s]};
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", s, obs);
            end
        end
        nxt();
    endtask

    task automatic test_write_basic();
        bit ack; int n_we; int bad; int gap;
        sel = 0;
        write_txn(2, 1'b1, 16'hFFFF, 16, ack, n_we, bad, gap);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_basic_ack: got %0b want 1", ack); end
        n_tests++; if (n_we != 4) begin n_fail++; $display("FAIL wr_basic_we_count: got %0d want 4", n_we); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wr_basic_beats: got %0d bad beats want 0", bad); end
        n_tests++; if (gap != 1) begin n_fail++; $display("FAIL wr_basic_done_latency: got %0d want 1", gap); end
        smp();
        n_tests++;
        if (busy[0] !== 1'b0 || wb_done[0] !== 1'b0) begin
            n_fail++; $display("FAIL wr_basic_idle: got busy=%0b done=%0b want 0 0", busy[0], wb_done[0]);
        end
        nxt();
    endtask

    task automatic test_read_basic();
        bit ack; bit ph; bit vld; logic [BW-1:0] d;
        sel = 0;
        read_txn(2, 3, ack, ph, vld, d);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_basic_ack: got %0b want 1", ack); end
        n_tests++; if (ph !== 1'b1) begin n_fail++; $display("FAIL rd_basic_sp_port: got %0b want 1", ph); end
        n_tests++; if (vld !== 1'b1) begin n_fail++; $display("FAIL rd_basic_valid: got %0b want 1", vld); end
        n_tests++; if (d !== 64'h44) begin n_fail++; $display("FAIL rd_basic_data: got %h want 44", d); end
        smp();
        n_tests++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 64'h44) begin
            n_fail++; $display("FAIL rd_basic_hold: got valid=%0b data=%h want 0 44", rd_valid[0], rd_data[0]);
        end
        nxt();
    endtask

    task automatic test_priority();
        int n_we; int bad; int gap;
        apply_reset();
        sel = 0;
        wb_start = 1'b1; wb_target = 2'd1;
        rd_req   = 1'b1; rd_target = 2'd2; rd_addr = 2'd1;
        smp();
        n_tests++;
        if (wb_ack[0] !== 1'b1 || rd_ack[0] !== 1'b0) begin
            n_fail++; $display("FAIL prio_first_write: got wb_ack=%0b rd_ack=%0b want 1 0", wb_ack[0], rd_ack[0]);
        end
        nxt();
        wb_start = 1'b0; m_last_wr = 1'b1;
        drive_burst(1, 1'b0, 16'hFFFF, 16, n_we, bad, gap);
        n_tests++;
        if (n_we != 4 || bad != 0 || gap != 1) begin
            n_fail++; $display("FAIL prio_burst: got we=%0d bad=%0d gap=%0d want 4 0 1", n_we, bad, gap);
        end
        wb_start = 1'b1; wb_target = 2'd3;
        smp();
        n_tests++;
        if (rd_ack[0] !== 1'b1 || wb_ack[0] !== 1'b0) begin
            n_fail++; $display("FAIL prio_second_read: got rd_ack=%0b wb_ack=%0b want 1 0", rd_ack[0], wb_ack[0]);
        end
        nxt();
        rd_req = 1'b0; m_last_wr = 1'b0;
        smp();
        n_tests++;
        if (wb_ack[0] !== 1'b0 || sp_mode[0] !== 1'b1) begin
            n_fail++; $display("FAIL prio_ignored_in_read: got wb_ack=%0b mode=%0b want 0 1", wb_ack[0], sp_mode[0]);
        end
        nxt();
        smp();
        n_tests++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== exp_rd(0, 2, 1) || wb_ack[0] !== 1'b1) begin
            n_fail++; $display("FAIL prio_t2: got valid=%0b data=%h wb_ack=%0b want 1 %h 1",
                               rd_valid[0], rd_data[0], wb_ack[0], exp_rd(0, 2, 1));
        end
        nxt();
        wb_start = 1'b0; m_last_wr = 1'b1;
        drive_burst(3, 1'b0, 16'hFFFF, 16, n_we, bad, gap);
        n_tests++;
        if (n_we != 4 || bad != 0 || gap != 1) begin
            n_fail++; $display("FAIL prio_burst2: got we=%0d bad=%0d gap=%0d want 4 0 1", n_we, bad, gap);
        end
    endtask

    task automatic test_gaps();
        bit ack; int n_we; int bad; int gap;
        sel = 0;
        // valid pattern 1,0,0,1,1,0,1 (bit 0 first)
        write_txn(0, 1'b0, 16'b0000_0000_0101_1001, 7, ack, n_we, bad, gap);
        n_tests++;
        if (ack !== 1'b1 || n_we != 4 || bad != 0 || gap != 1) begin
            n_fail++; $display("FAIL gaps_burst: got ack=%0b we=%0d bad=%0d gap=%0d want 1 4 0 1", ack, n_we, bad, gap);
        end
    endtask

    task automatic test_reset_mid();
        logic [141:0] obs;
        bit ack; int n_we; int bad; int gap; int dones;
        bit ph; bit vld; logic [BW-1:0] d;
        sel = 0;
        wb_start = 1'b1; wb_target = 2'd1;
        smp();
        n_tests++; if (wb_ack[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack: got %0b want 1", wb_ack[0]); end
        nxt();
        wb_start = 1'b0; m_last_wr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'b1;
            wb_data  = {$urandom, $urandom};
            ref_wr(1, i, wb_data);
            nxt();
        end
        wb_valid = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0; m_last_wr = 1'b0;
        smp();
        obs = {wb_ack[0], wb_ready[0], wb_done[0], rd_ack[0], rd_valid[0], busy[0], sp_we[0],
               sp_mode[0], sp_addr[0], sp_wt[0], sp_rt[0], rd_data[0], sp_do[0]};
        n_tests++; if (obs !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h want 0", obs); end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp();
            if (wb_done[0] || busy[0]) dones++;
        end
        n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
        nxt();
        write_txn(1, 1'b0, 16'hFFFF, 16, ack, n_we, bad, gap);
        n_tests++;
        if (ack !== 1'b1 || n_we != 4 || bad != 0 || gap != 1) begin
            n_fail++; $display("FAIL rstmid_restart: got ack=%0b we=%0d bad=%0d gap=%0d want 1 4 0 1", ack, n_we, bad, gap);
        end
        read_txn(1, 0, ack, ph, vld, d);
        n_tests++;
        if (vld !== 1'b1 || d !== exp_rd(0, 1, 0)) begin
            n_fail++; $display("FAIL rstmid_readback: got valid=%0b data=%h want 1 %h", vld, d, exp_rd(0, 1, 0));
        end
    endtask

    task automatic test_out_of_range();
        bit ack; int n_we; int bad; int gap;
        bit ph; bit vld; logic [BW-1:0] d;
        sel = 1;
        write_txn(3, 1'b0, 16'hFFFF, 16, ack, n_we, bad, gap);
        n_tests++;
        if (ack !== 1'b1 || n_we != 0 || bad != 0 || gap != 1) begin
            n_fail++; $display("FAIL oor_write: got ack=%0b we=%0d bad=%0d gap=%0d want 1 0 0 1", ack, n_we, bad, gap);
        end
        read_txn(3, 2, ack, ph, vld, d);
        n_tests++;
        if (ack !== 1'b1 || vld !== 1'b1 || d !== '0) begin
            n_fail++; $display("FAIL oor_read: got ack=%0b valid=%0b data=%h want 1 1 0", ack, vld, d);
        end
        // The 4-target controller saw the same traffic and must return the data.
        smp();
        n_tests++;
        if (rd_data[0] !== exp_rd(0, 3, 2)) begin
            n_fail++; $display("FAIL oor_inrange_peer: got %h want %h", rd_data[0], exp_rd(0, 3, 2));
        end
        nxt();
        sel = 0;
    endtask

    task automatic test_random();
        bit ack; int n_we; int bad; int gap;
        bit ph; bit vld; logic [BW-1:0] d;
        int kind; int wt; int rt; int ra; bit exp_wr_first;
        sel = 0;
        for (int t = 0; t < 4; t++) begin
            write_txn(t, 1'b0, 16'hFFFF, 16, ack, n_we, bad, gap);
            n_tests++;
            if (ack !== 1'b1 || n_we != 4 || bad != 0 || gap != 1) begin
                n_fail++; $display("FAIL rnd_fill t%0d: got ack=%0b we=%0d bad=%0d gap=%0d", t, ack, n_we, bad, gap);
            end
        end
        for (int it = 0; it < 30; it++) begin
            sel  = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            wt   = int'($urandom_range(0, 3));
            rt   = int'($urandom_range(0, 3));
            ra   = int'($urandom_range(0, 3));
            if (kind == 0) begin
                write_txn(wt, 1'b0, 16'($urandom_range(0, 255)), 8, ack, n_we, bad, gap);
                n_tests++;
                if (ack !== 1'b1 || n_we != exp_we(sel, wt) || bad != 0 || gap != 1) begin
                    n_fail++; $display("FAIL rnd_write it%0d: got ack=%0b we=%0d bad=%0d gap=%0d want 1 %0d 0 1",
                                       it, ack, n_we, bad, gap, exp_we(sel, wt));
                end
            end else if (kind == 1) begin
                read_txn(rt, ra, ack, ph, vld, d);
                n_tests++;
                if (ack !== 1'b1 || ph !== 1'b1 || vld !== 1'b1 || d !== exp_rd(sel, rt, ra)) begin
                    n_fail++; $display("FAIL rnd_read it%0d: got ack=%0b port=%0b valid=%0b data=%h want 1 1 1 %h",
                                       it, ack, ph, vld, d, exp_rd(sel, rt, ra));
                end
            end else begin
                exp_wr_first = !m_last_wr;
                wb_start = 1'b1; wb_target = TW'(wt);
                rd_req   = 1'b1; rd_target = TW'(rt); rd_addr = AW'(ra);
                smp();
                n_tests++;
                if (wb_ack[sel] !== exp_wr_first || rd_ack[sel] !== !exp_wr_first) begin
                    n_fail++; $display("FAIL rnd_conflict it%0d: got wb_ack=%0b rd_ack=%0b want %0b %0b",
                                       it, wb_ack[sel], rd_ack[sel], exp_wr_first, !exp_wr_first);
                end
                nxt();
                if (exp_wr_first) begin
                    wb_start = 1'b0; m_last_wr = 1'b1;
                    drive_burst(wt, 1'b0, 16'hFFFF, 16, n_we, bad, gap);
                    smp();
                    n_tests++;
                    if (n_we != exp_we(sel, wt) || bad != 0 || gap != 1 || rd_ack[sel] !== 1'b1) begin
                        n_fail++; $display("FAIL rnd_wr_then_rd it%0d: got we=%0d bad=%0d gap=%0d rd_ack=%0b",
                                           it, n_we, bad, gap, rd_ack[sel]);
                    end
                    nxt();
                    rd_req = 1'b0; m_last_wr = 1'b0;
                    nxt();
                    smp();
                    n_tests++;
                    if (rd_valid[sel] !== 1'b1 || rd_data[sel] !== exp_rd(sel, rt, ra)) begin
                        n_fail++; $display("FAIL rnd_late_read it%0d: got valid=%0b data=%h want 1 %h",
                                           it, rd_valid[sel], rd_data[sel], exp_rd(sel, rt, ra));
                    end
                    nxt();
                end else begin
                    rd_req = 1'b0; m_last_wr = 1'b0;
                    nxt();
                    smp();
                    n_tests++;
                    if (rd_valid[sel] !== 1'b1 || rd_data[sel] !== exp_rd(sel, rt, ra) || wb_ack[sel] !== 1'b1) begin
                        n_fail++; $display("FAIL rnd_rd_then_wr it%0d: got valid=%0b data=%h wb_ack=%0b want 1 %h 1",
                                           it, rd_valid[sel], rd_data[sel], wb_ack[sel], exp_rd(sel, rt, ra));
                    end
                    nxt();
                    wb_start = 1'b0; m_last_wr = 1'b1;
                    drive_burst(wt, 1'b0, 16'hFFFF, 16, n_we, bad, gap);
                    n_tests++;
                    if (n_we != exp_we(sel, wt) || bad != 0 || gap != 1) begin
                        n_fail++; $display("FAIL rnd_late_write it%0d: got we=%0d bad=%0d gap=%0d want %0d 0 1",
                                           it, n_we, bad, gap, exp_we(sel, wt));
                    end
                end
            end
            repeat ($urandom_range(0, 2)) nxt();
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_priority();
        test_gaps();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
